mcu_irq_ctrl: RTL and testbench
===============================

// Module: mcu_irq_ctrl
// PURPOSE
// Interrupt controller between up to NSRC on-chip requesters (sysctrl, sdc, hid, ...) and the single
// active-low interrupt line to the MCU. Latches and masks requests, grants one source at a time
// round-robin, and exposes the granted vector. It sequences the MCU acknowledge handshake, retries
// on ack timeout, and guarantees a minimum high time so the MCU always sees a fresh falling edge.
// PARAMETERS
// NSRC        8          number of interrupt sources (1..8)
// EDGE_MASK   8'h00      bit i = 1: source i rising-edge triggered; 0: level triggered
// HOLDOFF     16         cycles int_out_n is held high between two assertions (>=1)
// ACK_TIMEOUT 24'd1000000  cycles to wait for MCU ack before deassert+retry (0 = wait forever)
// PORTS
// clk          in   1     system clock
// reset_n      in   1     asynchronous, active-low reset
// src_req      in   NSRC  interrupt requests, synchronous to clk
// src_ack      out  NSRC  one-cycle ack pulse to source i when the MCU acks bit i
// mask_we      in   1     one-cycle strobe: load irq_mask from mask_data
// mask_data    in   NSRC  new mask, bit=1 enables source
// ack_strobe   in   1     one-cycle strobe: MCU acknowledges bits in ack_vec
// ack_vec      in   NSRC  acknowledge bitmap
// int_out_n    out  1     interrupt line to MCU, low = asserted
// irq_vector   out  3     index of currently/last granted source
// irq_pending  out  NSRC  pending bitmap (edge latches | live level requests), unmasked
// irq_mask     out  NSRC  current mask
// busy         out  1     high while state != IDLE
// BEHAVIOUR
// - Reset (async, reset_n=0): int_out_n=1, src_ack=0, irq_vector=0, irq_pending=0,
//   irq_mask=all ones, busy=0, state=IDLE, last_grant=NSRC-1, edge latches and counters cleared.
// - Pending: level i -> src_req[i] live; edge i -> latch set on src_req[i] 0->1 (reg'd previous value),
//   cleared when acked. Set and clear in same cycle: set wins. Latches ignore mask.
// - eligible = irq_pending & irq_mask. mask_we takes effect next cycle; masking a granted source
//   does not abort the current assertion.
// - src_ack registered: pulses exactly 1 cycle after ack_strobe, for ack_vec bits < NSRC only,
//   in any state (MCU may ack without an assertion).
// - FSM:
//   IDLE:   eligible!=0 -> pick first set bit scanning from last_grant+1 upward, wrapping mod NSRC;
//           irq_vector<=idx, int_out_n<=0, timer clear, -> ASSERT (1 cycle grant latency).
//   ASSERT: ack_strobe -> int_out_n<=1, -> HOLD; if ack_vec[irq_vector] then last_grant<=irq_vector
//           (else same source regrants next round). ACK_TIMEOUT!=0 and timer==ACK_TIMEOUT-1
//           -> int_out_n<=1, -> HOLD, last_grant unchanged (retry).
//   HOLD:   count HOLDOFF cycles with int_out_n=1, then -> IDLE. ack_strobe here acks/pulses only.
// - int_out_n low for >=1 cycle per grant; high for exactly HOLDOFF cycles before the next low.
// - Level source deasserting while granted: assertion continues until ack or timeout.
// - NSRC<8: unused ack_vec/mask bits ignored; irq_vector upper bits 0.
// - Counters saturate-free: timer 24 bit, holdoff counter $clog2(HOLDOFF+1) bits.
// TESTING
// - Reset: hold reset_n=0 mid-ASSERT -> int_out_n=1, busy=0, irq_mask=8'hFF immediately (async).
// - Single level src 2: src_req=8'h04 -> next cycle int_out_n=0, irq_vector=2; ack_vec=8'h04
//   -> src_ack=8'h04 one cycle later, int_out_n high 16 cycles, then re-asserts (req still high).
// - Round robin: src_req=8'h81 held, ack each grant -> irq_vector sequence 0,7,0,7.
// - Edge src 5 (EDGE_MASK=8'h20): one-cycle pulse -> irq_pending[5]=1 until acked; edge on the ack
//   cycle -> pending stays 1.
// - Mask: mask_data=8'hFB with src_req=8'h04 -> no assertion; unmask -> assertion next cycle+1.
// - Timeout (ACK_TIMEOUT=100): no ack -> int_out_n low 100 cycles, high 16, low again, irq_vector same.

Source files
------------

// File: rtl/mcu_irq_ctrl.sv
// Interrupt controller: latches/masks up to NSRC requests, grants one at a time round-robin
// on an active-low MCU line, sequences the ack handshake with timeout retry and a fixed high time.
module mcu_irq_ctrl #(
  parameter int          NSRC        = 8,
  parameter logic [7:0]  EDGE_MASK   = 8'h00,
  parameter int          HOLDOFF     = 16,
  parameter logic [23:0] ACK_TIMEOUT = 24'd1000000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] src_req,
  output logic [NSRC-1:0] src_ack,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_data,
  input  logic            ack_strobe,
  input  logic [NSRC-1:0] ack_vec,
  output logic            int_out_n,
  output logic [2:0]      irq_vector,
  output logic [NSRC-1:0] irq_pending,
  output logic [NSRC-1:0] irq_mask,
  output logic            busy,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam int              HW        = $clog2(HOLDOFF + 1);
  localparam logic [NSRC-1:0] EDGE_SEL  = EDGE_MASK[NSRC-1:0];
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLDOFF - 1);
  localparam logic [2:0]      LAST_RST  = 3'(NSRC - 1);

  state_e          state_q, state_d;
  logic            int_n_q, int_n_d;
  logic [2:0]      vec_q, vec_d;
  logic [2:0]      last_q, last_d;
  logic [23:0]     timer_q, timer_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [NSRC-1:0] mask_q, edge_q, edge_d, req_prev_q, ack_q;
  logic [NSRC-1:0] eligible, edge_set, edge_clr;
  logic            grant_valid;
  logic [2:0]      grant_idx;

  // Edge latches ignore the mask; a new edge beats a simultaneous ack clear.
  assign edge_set    = src_req & ~req_prev_q & EDGE_SEL;
  assign edge_clr    = ack_strobe ? ack_vec : '0;
  assign edge_d      = (edge_q & ~edge_clr) | edge_set;
  assign irq_pending = (edge_q & EDGE_SEL) | (src_req & ~EDGE_SEL);
  assign eligible    = irq_pending & mask_q;

  // Scan from last_grant+1 upward; descending loop so the nearest candidate is assigned last.
  always_comb begin
    int cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NSRC; k >= 1; k--) begin
      cand = (int'(last_q) + k) % NSRC;
      if (eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = 3'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    int_n_d = int_n_q;
    vec_d   = vec_q;
    last_d  = last_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          vec_d   = grant_idx;
          int_n_d = 1'b0;
          timer_d = '0;
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        timer_d = timer_q + 24'd1;
        if (ack_strobe) begin
          int_n_d = 1'b1;
          hold_d  = '0;
          state_d = ST_HOLD;
          if (ack_vec[vec_q]) last_d = vec_q;
        end else if (ACK_TIMEOUT != 24'd0 && timer_q == ACK_TIMEOUT - 24'd1) begin
          int_n_d = 1'b1;
          hold_d  = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Grant directly from the last hold cycle so the line is high for exactly HOLDOFF cycles.
        if (hold_q == HOLD_LAST) begin
          if (grant_valid) begin
            vec_d   = grant_idx;
            int_n_d = 1'b0;
            timer_d = '0;
            state_d = ST_ASSERT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      int_n_q    <= 1'b1;
      vec_q      <= '0;
      last_q     <= LAST_RST;
      timer_q    <= '0;
      hold_q     <= '0;
      mask_q     <= '1;
      edge_q     <= '0;
      req_prev_q <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      int_n_q    <= int_n_d;
      vec_q      <= vec_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
      if (mask_we) mask_q <= mask_data;
      edge_q     <= edge_d;
      req_prev_q <= src_req;
      ack_q      <= ack_strobe ? ack_vec : '0;
    end
  end

  assign src_ack     = ack_q;
  assign int_out_n   = int_n_q;
  assign irq_vector  = vec_q;
  assign irq_mask    = mask_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mcu_irq_ctrl.sv
// Directed bench for mcu_irq_ctrl: reset, level/edge grants, round robin, masking, ack timeout.
module tb_mcu_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] src_req, src_ack, mask_data, ack_vec, irq_pending, irq_mask;
  logic       mask_we, ack_strobe, int_out_n, busy;
  logic [2:0] irq_vector;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mcu_irq_ctrl #(
    .NSRC(8), .EDGE_MASK(8'h20), .HOLDOFF(16), .ACK_TIMEOUT(24'd100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .src_req(src_req), .src_ack(src_ack),
    .mask_we(mask_we), .mask_data(mask_data), .ack_strobe(ack_strobe), .ack_vec(ack_vec),
    .int_out_n(int_out_n), .irq_vector(irq_vector), .irq_pending(irq_pending),
    .irq_mask(irq_mask), .busy(busy), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mcu_ack(input logic [7:0] bits);
    ack_strobe = 1'b1;
    ack_vec    = bits;
    tick();
    ack_strobe = 1'b0;
    ack_vec    = 8'h00;
  endtask

  task automatic wait_idle();
    for (int w = 0; w < 40 && busy; w++) tick();
    check_eq("wait_idle", 32'(busy), 32'd0);
  endtask

  logic [2:0] exp_rr[4];
  int hc, lc;

  initial begin
    exp_rr = '{3'd0, 3'd7, 3'd0, 3'd7};
    reset_n = 1'b1; src_req = 8'h00; mask_we = 1'b0; mask_data = 8'h00;
    ack_strobe = 1'b0; ack_vec = 8'h00;
    #2 reset_n = 1'b0;
    tick(); tick();
    check_eq("rst_int_n",   32'(int_out_n),   32'd1);
    check_eq("rst_busy",    32'(busy),        32'd0);
    check_eq("rst_mask",    32'(irq_mask),    32'hFF);
    check_eq("rst_pending", 32'(irq_pending), 32'h00);
    check_eq("rst_vector",  32'(irq_vector),  32'd0);
    check_eq("rst_ack",     32'(src_ack),     32'h00);
    reset_n = 1'b1;
    tick();

    // single level source 2
    src_req = 8'h04;
    tick();
    check_eq("lvl_int_low", 32'(int_out_n),   32'd0);
    check_eq("lvl_vector",  32'(irq_vector),  32'd2);
    check_eq("lvl_busy",    32'(busy),        32'd1);
    check_eq("lvl_pending", 32'(irq_pending), 32'h04);
    check_eq("lvl_state",   32'(dbg_state),   32'd1);
    mcu_ack(8'h04);
    check_eq("lvl_int_high", 32'(int_out_n), 32'd1);
    check_eq("lvl_src_ack",  32'(src_ack),   32'h04);
    check_eq("lvl_state_h",  32'(dbg_state), 32'd2);
    hc = 1;
    tick();
    check_eq("lvl_ack_pulse", 32'(src_ack), 32'h00);
    if (int_out_n) hc++;
    for (int w = 0; w < 40 && int_out_n; w++) begin
      tick();
      if (int_out_n) hc++;
    end
    check_eq("lvl_holdoff",  32'(hc),         32'd16);
    check_eq("lvl_reassert", 32'(int_out_n),  32'd0);
    check_eq("lvl_revector", 32'(irq_vector), 32'd2);

    // asynchronous reset in the middle of an assertion
    reset_n = 1'b0;
    src_req = 8'h00;
    #1;
    check_eq("async_int_n", 32'(int_out_n), 32'd1);
    check_eq("async_busy",  32'(busy),      32'd0);
    check_eq("async_mask",  32'(irq_mask),  32'hFF);
    check_eq("async_state", 32'(dbg_state), 32'd0);
    tick();
    reset_n = 1'b1;

    // round robin between sources 0 and 7
    src_req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 40 && int_out_n; w++) tick();
      check_eq("rr_low",    32'(int_out_n),  32'd0);
      check_eq("rr_vector", 32'(irq_vector), 32'(exp_rr[i]));
      mcu_ack(8'h01 << exp_rr[i]);
    end
    src_req = 8'h00;
    wait_idle();

    // edge source 5
    src_req = 8'h20;
    tick();
    src_req = 8'h00;
    check_eq("edge_latched", 32'(irq_pending), 32'h20);
    check_eq("edge_no_yet",  32'(int_out_n),   32'd1);
    tick();
    check_eq("edge_int_low", 32'(int_out_n),   32'd0);
    check_eq("edge_vector",  32'(irq_vector),  32'd5);
    check_eq("edge_held",    32'(irq_pending), 32'h20);
    src_req = 8'h20;
    mcu_ack(8'h20);
    check_eq("edge_set_wins", 32'(irq_pending), 32'h20);
    check_eq("edge_src_ack",  32'(src_ack),     32'h20);
    src_req = 8'h00;
    tick();
    check_eq("edge_still",    32'(irq_pending), 32'h20);
    for (int w = 0; w < 40 && int_out_n; w++) tick();
    check_eq("edge_regrant",  32'(irq_vector),  32'd5);
    mcu_ack(8'h20);
    check_eq("edge_clr",      32'(irq_pending), 32'h00);
    wait_idle();

    // mask blocks source 2, unmask grants it one cycle after the load
    mask_we = 1'b1; mask_data = 8'hFB;
    tick();
    mask_we = 1'b0;
    check_eq("mask_loaded", 32'(irq_mask), 32'hFB);
    src_req = 8'h04;
    repeat (5) tick();
    check_eq("mask_no_int",  32'(int_out_n),   32'd1);
    check_eq("mask_idle",    32'(busy),        32'd0);
    check_eq("mask_pending", 32'(irq_pending), 32'h04);
    mask_we = 1'b1; mask_data = 8'hFF;
    tick();
    mask_we = 1'b0;
    check_eq("unmask_wait", 32'(int_out_n), 32'd1);
    tick();
    check_eq("unmask_int",  32'(int_out_n),  32'd0);
    check_eq("unmask_vec",  32'(irq_vector), 32'd2);

    // no ack: timeout after 100 low cycles, 16 high, then retry same source
    lc = 1;
    for (int w = 0; w < 200 && !int_out_n; w++) begin
      tick();
      if (!int_out_n) lc++;
    end
    check_eq("to_low_len", 32'(lc), 32'd100);
    hc = 1;
    for (int w = 0; w < 40 && int_out_n; w++) begin
      tick();
      if (int_out_n) hc++;
    end
    check_eq("to_high_len", 32'(hc),         32'd16);
    check_eq("to_retry",    32'(int_out_n),  32'd0);
    check_eq("to_vector",   32'(irq_vector), 32'd2);
    src_req = 8'h00;
    mcu_ack(8'h04);
    wait_idle();

    // ack with no assertion still pulses src_ack
    mcu_ack(8'h81);
    check_eq("idle_ack",      32'(src_ack), 32'h81);
    check_eq("idle_ack_busy", 32'(busy),    32'd0);
    tick();
    check_eq("idle_ack_end",  32'(src_ack), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
